// File: rtl/nark_exec_pkg.sv
// Shared execute-stage definitions: condition codes, ALU opcodes and NZCV bit positions.
package nark_exec_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/condition_check.sv
// Combinational condition-code evaluator against an NZCV flag set; shared with branch resolution.
module condition_check
    import nark_exec_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = nzcv[FLAG_N];
    assign z_s = nzcv[FLAG_Z];
    assign c_s = nzcv[FLAG_C];
    assign v_s = nzcv[FLAG_V];

    // Decode the condition code into a pass/fail decision.
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z_s;
            COND_NE: pass = !z_s;
            COND_CS: pass = c_s;
            COND_CC: pass = !c_s;
            COND_MI: pass = n_s;
            COND_PL: pass = !n_s;
            COND_VS: pass = v_s;
            COND_VC: pass = !v_s;
            COND_HI: pass = c_s && !z_s;
            COND_LS: pass = !c_s || z_s;
            COND_GE: pass = (n_s == v_s);
            COND_LT: pass = (n_s != v_s);
            COND_GT: pass = !z_s && (n_s == v_s);
            COND_LE: pass = z_s || (n_s != v_s);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: conditional execution, NZCV status register and a 2-entry
// writeback skid buffer (head register plus one overflow slot) toward the register file.
module alu_writeback_stage
    import nark_exec_pkg::*;
#(
    parameter int BITS       = 24,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [BITS-1:0]       IN_RST,
    input  logic [3:0]            IN_FLAGS,
    input  logic [1:0]            IN_OP,
    input  logic                  IN_SET_FLAGS,
    input  logic [3:0]            IN_COND,
    input  logic                  IN_WB_EN,
    input  logic [REG_ADDR_W-1:0] IN_RD,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [BITS-1:0]       OUT_DATA,
    output logic [REG_ADDR_W-1:0] OUT_RD,
    output logic [3:0]            STATUS_NZCV,
    output logic                  C_FLAG
);

    logic [3:0]            nzcv_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [BITS-1:0]       out_data_r;
    logic [REG_ADDR_W-1:0] out_rd_r;
    logic                  skid_valid_r;
    logic [BITS-1:0]       skid_data_r;
    logic [REG_ADDR_W-1:0] skid_rd_r;

    logic                  pass_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  flag_upd_s;
    logic                  out_valid_s;
    logic [BITS-1:0]       out_data_s;
    logic [REG_ADDR_W-1:0] out_rd_s;
    logic                  skid_valid_s;
    logic [BITS-1:0]       skid_data_s;
    logic [REG_ADDR_W-1:0] skid_rd_s;

    // Condition sees the flags as registered before this edge, never its own update.
    condition_check u_condition_check (
        .cond (IN_COND),
        .nzcv (nzcv_r),
        .pass (pass_s)
    );

    assign accept_s   = IN_VALID && in_ready_r;
    assign push_s     = accept_s && pass_s && IN_WB_EN;
    assign pop_s      = out_valid_r && OUT_READY;
    assign flag_upd_s = accept_s && pass_s && IN_SET_FLAGS && (IN_OP != OP_PASS);

    // Next-state of the head/skid pair; with both full, in_ready_r is low so no push can coincide.
    always_comb begin
        out_valid_s  = out_valid_r;
        out_data_s   = out_data_r;
        out_rd_s     = out_rd_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        skid_rd_s    = skid_rd_r;
        if (pop_s) begin
            if (skid_valid_r) begin
                out_data_s   = skid_data_r;
                out_rd_s     = skid_rd_r;
                skid_valid_s = 1'b0;
            end else if (push_s) begin
                out_data_s = IN_RST;
                out_rd_s   = IN_RD;
            end else begin
                out_valid_s = 1'b0;
            end
        end else if (push_s) begin
            if (!out_valid_r) begin
                out_valid_s = 1'b1;
                out_data_s  = IN_RST;
                out_rd_s    = IN_RD;
            end else begin
                skid_valid_s = 1'b1;
                skid_data_s  = IN_RST;
                skid_rd_s    = IN_RD;
            end
        end else begin
            out_valid_s = out_valid_r;
        end
    end

    // State registers; ready is precomputed so it never depends on OUT_READY combinationally.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            nzcv_r       <= 4'b0000;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_rd_r     <= '0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            skid_rd_r    <= '0;
        end else begin
            if (flag_upd_s) begin
                nzcv_r <= IN_FLAGS;
            end
            in_ready_r   <= !(out_valid_s && skid_valid_s);
            out_valid_r  <= out_valid_s;
            out_data_r   <= out_data_s;
            out_rd_r     <= out_rd_s;
            skid_valid_r <= skid_valid_s;
            skid_data_r  <= skid_data_s;
            skid_rd_r    <= skid_rd_s;
        end
    end

    assign IN_READY    = in_ready_r;
    assign OUT_VALID   = out_valid_r;
    assign OUT_DATA    = out_data_r;
    assign OUT_RD      = out_rd_r;
    assign STATUS_NZCV = nzcv_r;
    assign C_FLAG      = nzcv_r[FLAG_C];

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage with a writeback scoreboard and an independent NZCV model.
module tb_alu_writeback_stage;

    logic        CLK;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [23:0] IN_RST;
    logic [3:0]  IN_FLAGS;
    logic [1:0]  IN_OP;
    logic        IN_SET_FLAGS;
    logic [3:0]  IN_COND;
    logic        IN_WB_EN;
    logic [3:0]  IN_RD;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [23:0] OUT_DATA;
    logic [3:0]  OUT_RD;
    logic [3:0]  STATUS_NZCV;
    logic        C_FLAG;

    int checks = 0;
    int failures = 0;
    logic [3:0]  m_nzcv = 4'b0000;
    logic [27:0] sb[$];

    alu_writeback_stage #(.BITS(24), .REG_ADDR_W(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_RST       (IN_RST),
        .IN_FLAGS     (IN_FLAGS),
        .IN_OP        (IN_OP),
        .IN_SET_FLAGS (IN_SET_FLAGS),
        .IN_COND      (IN_COND),
        .IN_WB_EN     (IN_WB_EN),
        .IN_RD        (IN_RD),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .OUT_DATA     (OUT_DATA),
        .OUT_RD       (OUT_RD),
        .STATUS_NZCV  (STATUS_NZCV),
        .C_FLAG       (C_FLAG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[0]; z = f[1]; cy = f[2]; v = f[3];
        case (c)
            4'd0:  return z;
            4'd1:  return ~z;
            4'd2:  return cy;
            4'd3:  return ~cy;
            4'd4:  return n;
            4'd5:  return ~n;
            4'd6:  return v;
            4'd7:  return ~v;
            4'd8:  return cy & ~z;
            4'd9:  return ~cy | z;
            4'd10: return ~(n ^ v);
            4'd11: return n ^ v;
            4'd12: return ~z & ~(n ^ v);
            4'd13: return z | (n ^ v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Model one accepted instruction using the current inputs.
    task automatic predict();
        logic p;
        p = cond_model(IN_COND, m_nzcv);
        if (p && IN_WB_EN) sb.push_back({IN_RST, IN_RD});
        if (p && IN_SET_FLAGS && IN_OP != 2'b11) m_nzcv = IN_FLAGS;
    endtask

    task automatic offer(input logic [1:0] op, input logic set, input logic [3:0] flags,
                         input logic [3:0] cond, input logic wb, input logic [3:0] rd,
                         input logic [23:0] data);
        int n;
        IN_OP = op; IN_SET_FLAGS = set; IN_FLAGS = flags; IN_COND = cond;
        IN_WB_EN = wb; IN_RD = rd; IN_RST = data; IN_VALID = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!IN_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) check("accept_timeout", 32'd0, 32'd1);
        else predict();
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge CLK);
            n++;
        end
        repeat (2) @(posedge CLK);
        #1;
        check("drain_empty", sb.size(), 32'd0);
        check("drain_out_valid", OUT_VALID, 1'b0);
    endtask

    // Scoreboard consumer: every handshake on the output must match the oldest prediction.
    always @(negedge CLK) begin
        if (RESET && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {4'h0, OUT_DATA, OUT_RD}, 32'hFFFFFFFF);
            end else begin
                logic [27:0] e;
                e = sb.pop_front();
                check("wb_data", OUT_DATA, e[27:4]);
                check("wb_rd", OUT_RD, e[3:0]);
            end
        end
    end

    initial begin
        RESET = 1'b0; IN_VALID = 1'b0; IN_RST = 24'h0; IN_FLAGS = 4'h0; IN_OP = 2'b00;
        IN_SET_FLAGS = 1'b0; IN_COND = 4'd14; IN_WB_EN = 1'b0; IN_RD = 4'h0; OUT_READY = 1'b0;
        #12;
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_nzcv", STATUS_NZCV, 4'b0000);
        check("rst_out_valid", OUT_VALID, 1'b0);
        check("rst_in_ready", IN_READY, 1'b1);
        check("rst_c_flag", C_FLAG, 1'b0);
        check("rst_out_data", OUT_DATA, 24'h0);
        check("rst_out_rd", OUT_RD, 4'h0);

        // Single AL writeback: one-cycle latency, one-cycle pulse, data held after.
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        offer(2'b00, 1'b0, 4'h0, 4'd14, 1'b1, 4'd3, 24'h000005);
        check("lat_valid", OUT_VALID, 1'b1);
        check("lat_data", OUT_DATA, 24'h000005);
        check("lat_rd", OUT_RD, 4'd3);
        @(posedge CLK); #1;
        check("pulse_valid", OUT_VALID, 1'b0);
        check("hold_data", OUT_DATA, 24'h000005);
        check("hold_rd", OUT_RD, 4'd3);

        // CMP-like flag set, then EQ (passes) and NE (dropped).
        offer(2'b01, 1'b1, 4'b0010, 4'd14, 1'b0, 4'd0, 24'h000000);
        offer(2'b00, 1'b0, 4'h0, 4'd0, 1'b1, 4'd2, 24'h0000AA);
        offer(2'b00, 1'b0, 4'h0, 4'd1, 1'b1, 4'd4, 24'h0000BB);
        check("cmp_nzcv", STATUS_NZCV, 4'b0010);
        check("cmp_model", STATUS_NZCV, m_nzcv);
        drain();

        // Backpressure: two accepts fill the buffer, third waits for the first pop.
        OUT_READY = 1'b0;
        offer(2'b00, 1'b0, 4'h0, 4'd14, 1'b1, 4'd5, 24'h111111);
        offer(2'b00, 1'b0, 4'h0, 4'd14, 1'b1, 4'd6, 24'h222222);
        IN_OP = 2'b00; IN_SET_FLAGS = 1'b0; IN_COND = 4'd14; IN_WB_EN = 1'b1;
        IN_RD = 4'd7; IN_RST = 24'h333333; IN_VALID = 1'b1;
        @(negedge CLK);
        check("full_in_ready", IN_READY, 1'b0);
        check("full_out_valid", OUT_VALID, 1'b1);
        check("full_head_data", OUT_DATA, 24'h111111);
        @(negedge CLK);
        check("stall_head_data", OUT_DATA, 24'h111111);
        check("stall_head_rd", OUT_RD, 4'd5);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("pop_cycle_in_ready", IN_READY, 1'b0);
        @(negedge CLK);
        check("after_pop_in_ready", IN_READY, 1'b1);
        predict();
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        drain();

        // PASS-B leaves flags alone but still writes back.
        offer(2'b00, 1'b1, 4'b0100, 4'd14, 1'b0, 4'd0, 24'h000000);
        offer(2'b11, 1'b1, 4'b1111, 4'd14, 1'b1, 4'd8, 24'h123456);
        check("passb_nzcv", STATUS_NZCV, 4'b0100);
        check("passb_c_flag", C_FLAG, 1'b1);
        drain();

        // All condition codes against a changing flag state.
        for (int i = 0; i < 32; i++) begin
            logic [3:0] idx;
            idx = i[3:0];
            offer(2'($urandom_range(0, 3)), 1'b1, 4'($urandom), idx, 1'b1, idx, 24'($urandom));
        end
        check("sweep_nzcv", STATUS_NZCV, m_nzcv);
        check("sweep_c_flag", C_FLAG, m_nzcv[2]);
        drain();

        // Asynchronous reset with two entries buffered.
        offer(2'b00, 1'b1, 4'b1001, 4'd14, 1'b0, 4'd0, 24'h000000);
        OUT_READY = 1'b0;
        offer(2'b00, 1'b0, 4'h0, 4'd14, 1'b1, 4'd10, 24'hAAAAAA);
        offer(2'b00, 1'b0, 4'h0, 4'd14, 1'b1, 4'd11, 24'hBBBBBB);
        check("pre_rst_nzcv", STATUS_NZCV, 4'b1001);
        check("pre_rst_valid", OUT_VALID, 1'b1);
        #2;
        RESET = 1'b0;
        sb.delete();
        m_nzcv = 4'b0000;
        #1;
        check("async_rst_valid", OUT_VALID, 1'b0);
        check("async_rst_nzcv", STATUS_NZCV, 4'b0000);
        check("async_rst_c_flag", C_FLAG, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        OUT_READY = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("post_rst_valid", OUT_VALID, 1'b0);
            check("post_rst_in_ready", IN_READY, 1'b1);
        end
        @(posedge CLK); #1;
        offer(2'b00, 1'b0, 4'h0, 4'd14, 1'b1, 4'd9, 24'hABCDEF);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Execute-to-writeback stage directly downstream of the 24-bit ALU.
- Accepts the ALU result (RST), the four conditional flags and the instruction's control fields over a valid/ready handshake.
- Evaluates the instruction's 4-bit condition code against the architectural NZCV status register, updates that register, and queues writebacks in a 2-entry skid buffer toward the register file.
- Exports the current C flag back to the ALU CIN input.

Parameters:
- BITS, 24, datapath width; matches the ALU.
- REG_ADDR_W, 4, destination register index width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  upstream presents an executed instruction.
- IN_READY  out  1  stage can accept this cycle.
- IN_RST  in  BITS  ALU result.
- IN_FLAGS  in  4  ALU flags, [0]=N [1]=Z [2]=C [3]=V.
- IN_OP  in  2  ALU opcode: 00 ADD, 01 SUB, 10 MUL, 11 PASS-B.
- IN_SET_FLAGS  in  1  instruction requests a flag update.
- IN_COND  in  4  condition code.
- IN_WB_EN  in  1  instruction writes a destination register.
- IN_RD  in  REG_ADDR_W  destination register index.
- OUT_VALID  out  1  writeback entry available.
- OUT_READY  in  1  register file consumes the entry.
- OUT_DATA  out  BITS  writeback data.
- OUT_RD  out  REG_ADDR_W  writeback register index.
- STATUS_NZCV  out  4  architectural flags, same bit order as IN_FLAGS.
- C_FLAG  out  1  STATUS_NZCV[2], drives the ALU CIN.

Behaviour:
- Reset, asynchronous, active-low:
  - STATUS_NZCV=0000; buffer count=0.
  - OUT_VALID=0, OUT_DATA=0, OUT_RD=0; IN_READY=1 once RESET deasserts.
  - Reset mid-operation discards every buffered entry and all in-flight state.
- Accept: an instruction is accepted when IN_VALID && IN_READY.
  - IN_READY = (count < 2), taken from registered count only; no combinational path from OUT_READY.
- Condition evaluation:
  - PASS is computed at accept time from STATUS_NZCV as registered before this edge. An instruction never sees its own flag update.
  - Codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- Flag update: STATUS_NZCV <= IN_FLAGS on accept when PASS && IN_SET_FLAGS && IN_OP!=11. PASS-B never alters flags.
- Buffer push: on accept when PASS && IN_WB_EN, push {IN_RST, IN_RD}.
  - Failed-condition and no-writeback instructions are consumed silently and push nothing. Example: CMP is SET_FLAGS=1, WB_EN=0.
- Buffer pop: when OUT_VALID && OUT_READY.
  - FIFO order; OUT_DATA/OUT_RD show the head entry and hold stable while OUT_VALID && !OUT_READY.
- Simultaneous push and pop with count=1: count stays 1; the new entry becomes head in the next cycle.
- With count=2, IN_READY=0 even if OUT_READY=1 this cycle. IN_READY rises the cycle after the pop.
- Latency: an accepted writeback instruction is visible on OUT_* the cycle after acceptance (1 cycle) when the buffer was empty.
- Empty buffer: OUT_VALID=0, and OUT_DATA/OUT_RD hold their last values.

Decomposition:
- Shared package nark_exec_pkg:
  - Condition-code enum (COND_EQ..COND_NV).
  - ALU opcode constants (OP_ADD=00, OP_SUB=01, OP_MUL=10, OP_PASS=11).
  - Flag bit indices (FLAG_N=0, FLAG_Z=1, FLAG_C=2, FLAG_V=3).
- One sub-module, condition_check: combinational, takes cond + NZCV and returns pass. It is reused later by branch resolution.
- The skid buffer stays inline in this block.

Test Plan:
- Reset then idle -> STATUS_NZCV=0000, OUT_VALID=0, IN_READY=1, C_FLAG=0.
- ADD, COND=AL, WB_EN=1, RD=3, IN_RST=0x000005, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=0x000005, OUT_RD=3; one-cycle pulse.
- SUB with SET_FLAGS=1, IN_FLAGS=0010 (Z), WB_EN=0; then EQ with WB_EN=1, RD=2, IN_RST=0x0000AA; then NE with RD=4 -> STATUS_NZCV=0010; only RD=2/0x0000AA emerges; NE is dropped.
- OUT_READY=0 and three AL writebacks offered back to back -> IN_READY drops after 2 accepts; OUT_DATA holds the first entry. Raise OUT_READY -> entries drain in order, and the third is accepted the cycle after the first pop.
- PASS-B (OP=11), SET_FLAGS=1, IN_FLAGS=1111 with prior NZCV=0100 -> NZCV stays 0100 and C_FLAG=1; writeback still occurs.
- Assert RESET low asynchronously with 2 entries buffered and NZCV=1001 -> OUT_VALID falls immediately; NZCV=0000; after release IN_READY=1 and no stale entries appear.
